// File: rtl/itch_mold_parser.sv
`default_nettype none
// ============================================================================
// Module      : itch_mold_parser
// Description : Byte-serial MoldUDP64 / ITCH parser. Walks the Mold header,
//               then each length-prefixed message, and emits Add Order,
//               Delete Order and Order Executed records one cycle after the
//               last body byte. Truncated packets raise a dropErr pulse.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               inData/inValid/inLast - payload byte stream, no backpressure
//               addOrder/addValid     - 36-byte Add Order record + pulse
//               delOrder/delValid     - 19-byte Delete Order record + pulse
//               execOrder/execValid   - first 19 bytes of Order Executed + pulse
//               seqNum                - Mold sequence number of emitted message
//               dropErr               - pulse, packet ended early
// Revision    : 1.0 - initial release
// ============================================================================
module itch_mold_parser #(
    parameter int MAX_MSG_LEN = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   inData,
    input  logic         inValid,
    input  logic         inLast,
    output logic [287:0] addOrder,
    output logic         addValid,
    output logic [151:0] delOrder,
    output logic         delValid,
    output logic [151:0] execOrder,
    output logic         execValid,
    output logic [63:0]  seqNum,
    output logic         dropErr
);

    localparam logic [2:0]  c_MOLD_HDR  = 3'd0;
    localparam logic [2:0]  c_LEN_HI    = 3'd1;
    localparam logic [2:0]  c_LEN_LO    = 3'd2;
    localparam logic [2:0]  c_BODY      = 3'd3;
    localparam logic [2:0]  c_SKIP      = 3'd4;

    localparam logic [15:0] c_HDR_LAST  = 16'd19;
    localparam logic [15:0] c_ADD_LEN   = 16'd36;
    localparam logic [15:0] c_DEL_LEN   = 16'd19;
    localparam logic [15:0] c_EXEC_LEN  = 16'd31;
    localparam logic [15:0] c_MAX_LEN   = 16'(MAX_MSG_LEN);
    // The shift register holds 35 bytes; the 36th byte of an Add Order is
    // the final byte and is taken straight from inData on the emit cycle.
    localparam logic [15:0] c_KEEP      = 16'd35;
    localparam logic [7:0]  c_TYPE_ADD  = 8'h41;
    localparam logic [7:0]  c_TYPE_DEL  = 8'h44;
    localparam logic [7:0]  c_TYPE_EXEC = 8'h45;

    logic [2:0]   r_state;
    logic [2:0]   w_nextState;
    logic [15:0]  r_byteCnt;
    logic [15:0]  r_msgCnt;
    logic [15:0]  r_msgIdx;
    logic [15:0]  r_len;
    logic [63:0]  r_seqBase;
    logic [279:0] r_body;

    logic [287:0] w_bodyNext;
    logic [15:0]  w_len;
    logic [15:0]  w_hdrCnt;
    logic         w_hdrDone;
    logic         w_heartbeat;
    logic         w_lastMsg;
    logic         w_finalByte;
    logic         w_lenOk;
    logic         w_bodyEnd;
    logic         w_emitAdd;
    logic         w_emitDel;
    logic         w_emitExec;
    logic         w_drop;
    logic         w_toHdr;

    // Body bytes including the one arriving now; byte 0 ends at the MSB of
    // whichever record width matches the message length.
    assign w_bodyNext  = {r_body, inData};
    assign w_len       = {r_len[15:8], inData};
    assign w_hdrCnt    = {r_msgCnt[7:0], inData};
    assign w_hdrDone   = (r_byteCnt == c_HDR_LAST);
    assign w_heartbeat = (w_hdrCnt == 16'h0000) || (w_hdrCnt == 16'hFFFF);
    assign w_lastMsg   = ((r_msgIdx + 16'd1) == r_msgCnt);
    assign w_finalByte = (r_byteCnt == (r_len - 16'd1));
    assign w_lenOk     = (r_len <= c_MAX_LEN);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_MOLD_HDR;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        if (inValid) begin
            case (r_state)
                c_MOLD_HDR: begin
                    if (inLast) begin
                        w_nextState = c_MOLD_HDR;
                    end else if (w_hdrDone) begin
                        w_nextState = w_heartbeat ? c_SKIP : c_LEN_HI;
                    end
                end
                c_LEN_HI: begin
                    w_nextState = inLast ? c_MOLD_HDR : c_LEN_LO;
                end
                c_LEN_LO: begin
                    if (inLast) begin
                        w_nextState = c_MOLD_HDR;
                    end else if (w_len == 16'd0) begin
                        w_nextState = w_lastMsg ? c_SKIP : c_LEN_HI;
                    end else begin
                        w_nextState = c_BODY;
                    end
                end
                c_BODY: begin
                    if (inLast) begin
                        w_nextState = c_MOLD_HDR;
                    end else if (w_finalByte) begin
                        w_nextState = w_lastMsg ? c_SKIP : c_LEN_HI;
                    end
                end
                c_SKIP: begin
                    if (inLast) begin
                        w_nextState = c_MOLD_HDR;
                    end
                end
                default: w_nextState = c_MOLD_HDR;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_drop = 1'b0;
        if (inValid && inLast) begin
            case (r_state)
                // A heartbeat / end-of-session header may legitimately end
                // the packet on its last header byte.
                c_MOLD_HDR: w_drop = !(w_hdrDone && w_heartbeat);
                c_LEN_HI:   w_drop = 1'b1;
                c_LEN_LO:   w_drop = !((w_len == 16'd0) && w_lastMsg);
                c_BODY:     w_drop = !(w_finalByte && w_lastMsg);
                default:    w_drop = 1'b0;
            endcase
        end
        w_bodyEnd  = inValid && (r_state == c_BODY) && w_finalByte;
        w_emitAdd  = w_bodyEnd && w_lenOk && (r_len == c_ADD_LEN)
                     && (w_bodyNext[287:280] == c_TYPE_ADD);
        w_emitDel  = w_bodyEnd && w_lenOk && (r_len == c_DEL_LEN)
                     && (w_bodyNext[151:144] == c_TYPE_DEL);
        w_emitExec = w_bodyEnd && w_lenOk && (r_len == c_EXEC_LEN)
                     && (w_bodyNext[247:240] == c_TYPE_EXEC);
        // Entering the header from anywhere other than the normal header
        // walk clears the per-packet counters.
        w_toHdr    = inValid && (w_nextState == c_MOLD_HDR)
                     && ((r_state != c_MOLD_HDR) || inLast);
    end

    // ------------------------------------------------------------------
    // Counters and capture registers. The session id (header bytes 0-9)
    // has no consumer downstream, so those bytes are only counted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byteCnt <= 16'd0;
            r_msgCnt  <= 16'd0;
            r_msgIdx  <= 16'd0;
            r_len     <= 16'd0;
            r_seqBase <= 64'd0;
            r_body    <= '0;
        end else if (inValid) begin
            if (w_toHdr) begin
                r_byteCnt <= 16'd0;
                r_msgCnt  <= 16'd0;
                r_msgIdx  <= 16'd0;
                r_len     <= 16'd0;
            end else begin
                case (r_state)
                    c_MOLD_HDR: begin
                        r_byteCnt <= w_hdrDone ? 16'd0 : (r_byteCnt + 16'd1);
                        if ((r_byteCnt >= 16'd10) && (r_byteCnt <= 16'd17)) begin
                            r_seqBase <= {r_seqBase[55:0], inData};
                        end
                        if (r_byteCnt >= 16'd18) begin
                            r_msgCnt <= w_hdrCnt;
                        end
                    end
                    c_LEN_HI: begin
                        r_len <= {inData, 8'h00};
                    end
                    c_LEN_LO: begin
                        r_len     <= w_len;
                        r_byteCnt <= 16'd0;
                        if (w_len == 16'd0) begin
                            r_msgIdx <= r_msgIdx + 16'd1;
                        end
                    end
                    c_BODY: begin
                        if (r_byteCnt < c_KEEP) begin
                            r_body <= w_bodyNext[279:0];
                        end
                        if (w_finalByte) begin
                            r_byteCnt <= 16'd0;
                            r_msgIdx  <= r_msgIdx + 16'd1;
                        end else begin
                            r_byteCnt <= r_byteCnt + 16'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs; records hold until the next emission.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            addValid  <= 1'b0;
            delValid  <= 1'b0;
            execValid <= 1'b0;
            dropErr   <= 1'b0;
            addOrder  <= '0;
            delOrder  <= '0;
            execOrder <= '0;
            seqNum    <= 64'd0;
        end else begin
            addValid  <= w_emitAdd;
            delValid  <= w_emitDel;
            execValid <= w_emitExec;
            dropErr   <= w_drop;
            if (w_emitAdd) begin
                addOrder <= w_bodyNext;
            end
            if (w_emitDel) begin
                delOrder <= w_bodyNext[151:0];
            end
            if (w_emitExec) begin
                execOrder <= w_bodyNext[247:96];
            end
            if (w_emitAdd || w_emitDel || w_emitExec) begin
                seqNum <= r_seqBase + {48'd0, r_msgIdx};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_itch_mold_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_itch_mold_parser
// Description : Self-checking bench for itch_mold_parser. Single-message
//               packets come from a vector table; multi-message, gapped,
//               wrap-around and mid-packet-reset cases are hand sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_itch_mold_parser;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   inData;
    logic         inValid;
    logic         inLast;
    logic [287:0] addOrder;
    logic         addValid;
    logic [151:0] delOrder;
    logic         delValid;
    logic [151:0] execOrder;
    logic         execValid;
    logic [63:0]  seqNum;
    logic         dropErr;

    always #5 clk = ~clk;

    itch_mold_parser #(.MAX_MSG_LEN(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .inData   (inData),
        .inValid  (inValid),
        .inLast   (inLast),
        .addOrder (addOrder),
        .addValid (addValid),
        .delOrder (delOrder),
        .delValid (delValid),
        .execOrder(execOrder),
        .execValid(execValid),
        .seqNum   (seqNum),
        .dropErr  (dropErr)
    );

    // ---------------- monitor ----------------
    int           cyc = 0;
    int           nAdd = 0, nDel = 0, nExec = 0, nDrop = 0, nMulti = 0;
    int           dropCyc = 0;
    logic [287:0] gotAdd;
    logic [151:0] gotDel, gotExec;
    logic [63:0]  seqLog[$];
    int           kindLog[$];
    int           cycLog[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (addValid) begin
                nAdd <= nAdd + 1; gotAdd <= addOrder;
                seqLog.push_back(seqNum); kindLog.push_back(1); cycLog.push_back(cyc);
            end
            if (delValid) begin
                nDel <= nDel + 1; gotDel <= delOrder;
                seqLog.push_back(seqNum); kindLog.push_back(2); cycLog.push_back(cyc);
            end
            if (execValid) begin
                nExec <= nExec + 1; gotExec <= execOrder;
                seqLog.push_back(seqNum); kindLog.push_back(3); cycLog.push_back(cyc);
            end
            if (dropErr) begin
                nDrop <= nDrop + 1; dropCyc <= cyc;
            end
            if (int'(addValid) + int'(delValid) + int'(execValid) > 1) nMulti <= nMulti + 1;
        end
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- packet builder / driver ----------------
    logic [7:0]   pkt[$];
    logic [7:0]   bodyB[0:127];
    logic [287:0] expA;
    logic [151:0] expD, expE;
    int           msgEnd = -1;
    int           endAcc = 0;
    int           lastAcc = 0;

    task automatic startPkt(input logic [63:0] seq, input logic [15:0] cnt);
        pkt.delete();
        msgEnd = -1;
        for (int i = 0; i < 10; i++) pkt.push_back(8'(8'hA0 + i));
        for (int i = 7; i >= 0; i--) pkt.push_back(seq[i*8 +: 8]);
        pkt.push_back(cnt[15:8]);
        pkt.push_back(cnt[7:0]);
    endtask

    task automatic fillBody(input logic [7:0] typ, input int seed);
        bodyB[0] = typ;
        for (int k = 1; k < 128; k++) bodyB[k] = 8'(k * 13 + seed);
    endtask

    // Appends length + body; builds the expected record with byte 0 at MSB.
    task automatic commitMsg(input int len);
        pkt.push_back(8'(len >> 8));
        pkt.push_back(8'(len));
        for (int k = 0; k < len; k++) pkt.push_back(bodyB[k]);
        msgEnd = pkt.size() - 1;
        if (bodyB[0] == 8'h41) begin
            expA = '0;
            for (int k = 0; k < 36; k++) expA[287 - 8*k -: 8] = bodyB[k];
        end
        if (bodyB[0] == 8'h44) begin
            expD = '0;
            for (int k = 0; k < 19; k++) expD[151 - 8*k -: 8] = bodyB[k];
        end
        if (bodyB[0] == 8'h45) begin
            expE = '0;
            for (int k = 0; k < 19; k++) expE[151 - 8*k -: 8] = bodyB[k];
        end
    endtask

    task automatic addPad(input int n);
        for (int i = 0; i < n; i++) pkt.push_back(8'h5A);
    endtask

    task automatic buildReq32();
        logic [63:0] refNum;
        refNum = 64'h1122334455667788;
        startPkt(64'h100, 16'd1);
        fillBody(8'h41, 7);
        for (int k = 0; k < 8; k++) bodyB[11 + k] = refNum[63 - 8*k -: 8];
        bodyB[20] = 8'h00; bodyB[21] = 8'h00; bodyB[22] = 8'h00; bodyB[23] = 8'h64;
        bodyB[32] = 8'h00; bodyB[33] = 8'h0F; bodyB[34] = 8'h42; bodyB[35] = 8'h40;
        commitMsg(36);
    endtask

    // gap: idle cycles between bytes (inLast=1 garbage while idle);
    // truncAt: index carrying inLast (-1 = last byte); rstAt: byte index
    // presented together with a 2-cycle reset, after which sending stops.
    task automatic sendPkt(input int gap, input int truncAt, input int rstAt);
        int n;
        n = (truncAt >= 0) ? truncAt + 1 : pkt.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            inValid = 1'b1; inData = pkt[i]; inLast = 1'b0;
            if (i == rstAt) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0; inValid = 1'b0;
                return;
            end
            inLast = (i == n - 1);
            if (i == msgEnd) endAcc = cyc + 1;
            if (i == n - 1) lastAcc = cyc + 1;
            for (int g = 0; g < gap && i < n - 1; g++) begin
                @(negedge clk);
                inValid = 1'b0; inData = 8'hEE; inLast = 1'b1;
            end
        end
        @(negedge clk);
        inValid = 1'b0; inLast = 1'b0; inData = 8'h00;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [63:0] seq;
        logic [15:0] cnt;
        logic [7:0]  typ;
        int          len;
        int          trunc;
        int          pad;
        int          eAdd, eDel, eExec, eDrop;
    } vec_t;

    vec_t vecs[11];
    int   bA, bD, bE, bX, bS;

    initial begin
        vecs[0]  = '{64'h100, 16'd1, 8'h41, 36, -1, 0, 1, 0, 0, 0};
        vecs[1]  = '{64'h200, 16'd1, 8'h44, 19, -1, 2, 0, 1, 0, 0};
        vecs[2]  = '{64'h300, 16'd1, 8'h45, 31, -1, 0, 0, 0, 1, 0};
        vecs[3]  = '{64'h400, 16'd1, 8'h41, 30, -1, 0, 0, 0, 0, 0};
        vecs[4]  = '{64'h500, 16'd1, 8'h58, 20, -1, 0, 0, 0, 0, 0};
        vecs[5]  = '{64'h600, 16'd1, 8'h41, 70, -1, 1, 0, 0, 0, 0};
        vecs[6]  = '{64'h700, 16'h0000, 8'h00, 0, -1, 10, 0, 0, 0, 0};
        vecs[7]  = '{64'h800, 16'hFFFF, 8'h00, 0, -1, 3, 0, 0, 0, 0};
        vecs[8]  = '{64'h900, 16'd1, 8'h41, 36, 42, 0, 0, 0, 0, 1};
        vecs[9]  = '{64'hA00, 16'd1, 8'h44, 19, 5, 0, 0, 0, 0, 1};
        vecs[10] = '{64'hFFFF_FFFF_FFFF_FFFE, 16'd1, 8'h45, 31, -1, 0, 0, 0, 1, 0};

        rst = 1'b1; inValid = 1'b0; inLast = 1'b0; inData = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst valids", {addValid, delValid, execValid, dropErr}, 0);
        chk("rst addOrder", addOrder, 0);
        chk("rst delOrder", delOrder, 0);
        chk("rst execOrder", execOrder, 0);
        chk("rst seqNum", seqNum, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            startPkt(vecs[v].seq, vecs[v].cnt);
            if (vecs[v].cnt != 16'h0000 && vecs[v].cnt != 16'hFFFF) begin
                fillBody(vecs[v].typ, v);
                commitMsg(vecs[v].len);
            end
            addPad(vecs[v].pad);
            bA = nAdd; bD = nDel; bE = nExec; bX = nDrop; bS = seqLog.size();
            sendPkt(0, vecs[v].trunc, -1);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d addCount", v), nAdd - bA, vecs[v].eAdd);
            chk($sformatf("v%0d delCount", v), nDel - bD, vecs[v].eDel);
            chk($sformatf("v%0d execCount", v), nExec - bE, vecs[v].eExec);
            chk($sformatf("v%0d dropCount", v), nDrop - bX, vecs[v].eDrop);
            if (vecs[v].eAdd + vecs[v].eDel + vecs[v].eExec == 1 && seqLog.size() > bS) begin
                chk($sformatf("v%0d seqNum", v), seqLog[bS], vecs[v].seq);
                chk($sformatf("v%0d latency", v), cycLog[bS], endAcc);
                if (vecs[v].eAdd == 1) chk($sformatf("v%0d addOrder", v), gotAdd, expA);
                if (vecs[v].eDel == 1) chk($sformatf("v%0d delOrder", v), gotDel, expD);
                if (vecs[v].eExec == 1) chk($sformatf("v%0d execOrder", v), gotExec, expE);
            end
            if (vecs[v].eDrop == 1) chk($sformatf("v%0d dropLatency", v), dropCyc, lastAcc);
        end

        // A, D, E in one packet, inLast on the final byte
        startPkt(64'd5, 16'd3);
        fillBody(8'h41, 21); commitMsg(36);
        fillBody(8'h44, 22); commitMsg(19);
        fillBody(8'h45, 23); commitMsg(31);
        bA = nAdd; bD = nDel; bE = nExec; bX = nDrop; bS = seqLog.size();
        sendPkt(0, -1, -1);
        repeat (3) @(negedge clk);
        chk("ade counts", {32'(nAdd - bA), 32'(nDel - bD), 32'(nExec - bE), 32'(nDrop - bX)},
            {32'd1, 32'd1, 32'd1, 32'd0});
        if (seqLog.size() >= bS + 3) begin
            chk("ade order", {32'(kindLog[bS]), 32'(kindLog[bS+1]), 32'(kindLog[bS+2])},
                {32'd1, 32'd2, 32'd3});
            chk("ade seqNums", {seqLog[bS], seqLog[bS+1], seqLog[bS+2]}, {64'd5, 64'd6, 64'd7});
            chk("ade exec latency", cycLog[bS+2], endAcc);
        end
        chk("ade addOrder", gotAdd, expA);
        chk("ade delOrder", gotDel, expD);
        chk("ade execOrder", gotExec, expE);

        // Single add with a bubble between every byte
        buildReq32();
        bA = nAdd; bS = seqLog.size();
        sendPkt(1, -1, -1);
        repeat (3) @(negedge clk);
        chk("gap addCount", nAdd - bA, 1);
        chk("gap addOrder", gotAdd, expA);
        chk("gap msgType", gotAdd[287:280], 8'h41);
        chk("gap refNum", gotAdd[199:136], 64'h1122334455667788);
        chk("gap shares", gotAdd[127:96], 32'd100);
        chk("gap price", gotAdd[31:0], 32'h000F4240);
        if (seqLog.size() > bS) begin
            chk("gap seqNum", seqLog[bS], 64'h100);
            chk("gap latency", cycLog[bS], endAcc);
        end

        // Reset at header byte 12, then a full packet
        bA = nAdd; bX = nDrop; bS = seqLog.size();
        buildReq32();
        sendPkt(0, -1, 12);
        repeat (2) @(negedge clk);
        buildReq32();
        sendPkt(0, -1, -1);
        repeat (3) @(negedge clk);
        chk("rstmid addCount", nAdd - bA, 1);
        chk("rstmid dropCount", nDrop - bX, 0);
        chk("rstmid addOrder", gotAdd, expA);
        if (seqLog.size() > bS) chk("rstmid seqNum", seqLog[bS], 64'h100);

        // Sequence number wraps modulo 2^64
        startPkt(64'hFFFF_FFFF_FFFF_FFFF, 16'd2);
        fillBody(8'h44, 31); commitMsg(19);
        fillBody(8'h44, 32); commitMsg(19);
        bD = nDel; bS = seqLog.size();
        sendPkt(0, -1, -1);
        repeat (3) @(negedge clk);
        chk("wrap delCount", nDel - bD, 2);
        if (seqLog.size() >= bS + 2)
            chk("wrap seqNums", {seqLog[bS], seqLog[bS+1]}, {64'hFFFF_FFFF_FFFF_FFFF, 64'd0});

        // Packet ends in the second message's length field
        startPkt(64'h50, 16'd2);
        fillBody(8'h44, 41); commitMsg(19);
        pkt.push_back(8'h00);
        pkt.push_back(8'd19);
        bD = nDel; bX = nDrop;
        sendPkt(0, pkt.size() - 2, -1);
        repeat (3) @(negedge clk);
        chk("shortpkt delCount", nDel - bD, 1);
        chk("shortpkt delOrder", gotDel, expD);
        chk("shortpkt dropCount", nDrop - bX, 1);
        chk("shortpkt dropLatency", dropCyc, lastAcc);

        chk("oneValidPerCycle", nMulti, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/itch_mold_parser.md
ITCH_MOLD_PARSER -- requirements
Module: itch_mold_parser

Interface
REQ-001 SHALL have parameter MAX_MSG_LEN, default 64, meaning the largest accepted ITCH message length in bytes; longer messages are skipped.
REQ-002 SHALL have port clk  input  1  sole clock; all logic is on the rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port inData  input  8  UDP payload byte (MoldUDP64), big-endian, first byte to MSB.
REQ-005 SHALL have port inValid  input  1  inData is valid this cycle; no backpressure.
REQ-006 SHALL have port inLast  input  1  qualified by inValid; marks the last payload byte of a packet.
REQ-007 SHALL have port addOrder  output  288  itchAddOrderType from the package.
REQ-008 SHALL have port addValid  output  1  one-cycle pulse; addOrder is valid.
REQ-009 SHALL have port delOrder  output  152  itchDeleteOrderType.
REQ-010 SHALL have port delValid  output  1  one-cycle pulse.
REQ-011 SHALL have port execOrder  output  152  itchOrderExecutedType.
REQ-012 SHALL have port execValid  output  1  one-cycle pulse.
REQ-013 SHALL have port seqNum  output  64  Mold sequence number of the emitted message.
REQ-014 SHALL have port dropErr  output  1  one-cycle pulse; the packet was truncated.

Function
REQ-015 SHALL implement states MOLD_HDR, LEN_HI, LEN_LO, BODY and SKIP, with the state and all counters advancing only on cycles where inValid=1.
REQ-016 MOLD_HDR SHALL capture 20 bytes:
- bytes 0-9: sessId
- bytes 10-17: seqNum base
- bytes 18-19: msgCnt
After byte 19 it goes to LEN_HI.
REQ-017 If msgCnt is 0x0000 (heartbeat) or 0xFFFF (end of session), the parser SHALL go to SKIP and emit nothing.
REQ-018 LEN_HI and LEN_LO SHALL capture the 16-bit message length.
- len=0: the message counts as processed and produces no output; the parser goes to LEN_HI.
- Otherwise the parser goes to BODY.
REQ-019 BODY SHALL shift the body bytes into a 36-byte register, so that byte 0 (msgType) lands at the struct MSB after the final byte.
- The first 36 bytes are kept.
- Bytes beyond 36 are counted but discarded.
REQ-020 On the final body byte, the output is decided by msgType and len:
- msgType 0x41 with len=36: registered addOrder and addValid.
- msgType 0x44 with len=19: registered delOrder and delValid.
- msgType 0x45 with len=31: registered execOrder and execValid, taken from body bytes 0-18.
- Any other type or length mismatch: no output, and the message still counts.
REQ-021 The output latency SHALL be exactly 1 cycle after the final body byte is accepted.
- Struct outputs hold their value until the next emission.
- At most one valid is asserted per cycle.
REQ-022 seqNum SHALL equal the header seqNum plus the zero-based message index, computed modulo 2^64.
REQ-023 When len > MAX_MSG_LEN, the body bytes SHALL be consumed without any output and the message SHALL count.
REQ-024 After msgCnt messages, the parser SHALL go to SKIP, discard bytes until inLast, and then go to MOLD_HDR.
REQ-025 inLast on the final body byte of message msgCnt SHALL emit normally and then go to MOLD_HDR.
REQ-026 inLast in any earlier position (header, length, mid-body, or before msgCnt messages are complete) SHALL:
- pulse dropErr for 1 cycle, one cycle later;
- suppress the partial message;
- go to MOLD_HDR.
REQ-027 inLast while in SKIP SHALL go to MOLD_HDR without raising dropErr.
REQ-028 The message counter, byte counter and length SHALL be 16 bits wide and SHALL clear on every entry to MOLD_HDR.

Reset
REQ-029 While rst=1, the block SHALL drive these outputs to 0: addValid, delValid, execValid, dropErr, addOrder, delOrder, execOrder and seqNum.
REQ-030 While rst=1, the state SHALL be MOLD_HDR and all counters and capture registers SHALL be 0.
REQ-031 Reset asserted mid-packet SHALL discard that packet with no output or dropErr; the parser SHALL then treat the next valid byte after rst deasserts as Mold header byte 0.

Verification
REQ-032 Single add: seq=0x100, msgCnt=1, len=36, 'A', refNum=0x1122334455667788, shares=100, price=0x000F4240 -> one addValid pulse 1 cycle after the last byte, fields exact, seqNum=0x100.
REQ-033 Three messages A, D, E with seq=5 and inLast on the final byte -> addValid, delValid and execValid in order, with seqNum 5, 6, 7 and no dropErr.
REQ-034 Heartbeat msgCnt=0 followed by 10 padding bytes -> no valids and no dropErr; the next packet parses correctly.
REQ-035 Truncation: inLast at body byte 20 of a 36-byte 'A' -> dropErr pulse, no addValid; the following valid packet emits normally.
REQ-036 The REQ-032 packet with inValid low on every other cycle -> identical addOrder, with addValid 1 cycle after the last valid byte.
REQ-037 rst asserted at header byte 12, then a full REQ-032 packet -> exactly one correct addValid.
